// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - state encodings and shift codes for the 8x8 sequential multiplier control
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    LSB       = 3'b001,
    MID       = 3'b010,
    MSB       = 3'b011,
    CALC_DONE = 3'b100,
    ERR       = 3'b101
  } state_e;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

endpackage

// File: rtl/mult_control.sv
// rtl/mult_control.sv - control FSM stepping one 4x4 multiplier through four partial products
// Registered state, Mealy outputs decoded from state, start and the external cycle count.
module mult_control
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  input  logic [1:0] count,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic [2:0] state_out,
  output logic       done,
  output logic       clk_ena,
  output logic       sclr_n
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

  always_comb begin
    state_d   = state_q;
    input_sel = 2'b00;
    shift_sel = SH0;
    done      = 1'b0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          clk_ena = 1'b1;
          sclr_n  = 1'b0;
          state_d = LSB;
        end
      end

      LSB: begin
        if (!start && count == 2'b00) begin
          input_sel = 2'b00;
          shift_sel = SH0;
          clk_ena   = 1'b1;
          state_d   = MID;
        end else begin
          state_d = ERR;
        end
      end

      // Both cross products share the <<4 shift; only the nibble select differs.
      MID: begin
        if (!start && count == 2'b01) begin
          input_sel = 2'b01;
          shift_sel = SH4;
          clk_ena   = 1'b1;
          state_d   = MID;
        end else if (!start && count == 2'b10) begin
          input_sel = 2'b10;
          shift_sel = SH4;
          clk_ena   = 1'b1;
          state_d   = MSB;
        end else begin
          state_d = ERR;
        end
      end

      MSB: begin
        if (!start && count == 2'b11) begin
          input_sel = 2'b11;
          shift_sel = SH8;
          clk_ena   = 1'b1;
          state_d   = CALC_DONE;
        end else begin
          state_d = ERR;
        end
      end

      CALC_DONE: begin
        if (!start) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ERR;
        end
      end

      ERR: begin
        if (start) begin
          clk_ena = 1'b1;
          sclr_n  = 1'b0;
          state_d = LSB;
        end
      end

      // Unused codes 110/111 fall back to IDLE with default outputs.
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - directed self-checking bench for mult_control
module tb_mult_control;

  logic       clk;
  logic       reset_a;
  logic       start;
  logic [1:0] count;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic [2:0] state_out;
  logic       done;
  logic       clk_ena;
  logic       sclr_n;

  int checks;
  int failures;

  mult_control dut (
    .clk      (clk),
    .reset_a  (reset_a),
    .start    (start),
    .count    (count),
    .input_sel(input_sel),
    .shift_sel(shift_sel),
    .state_out(state_out),
    .done     (done),
    .clk_ena  (clk_ena),
    .sclr_n   (sclr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, let the Mealy outputs settle, then sample.
  task automatic apply(input logic s, input logic [1:0] c);
    @(negedge clk);
    start = s;
    count = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  // Compact check of all outputs against expected values.
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] isel,
                         input logic [1:0] ssel, input logic dn, input logic ena, input logic clr_n);
    chk({tag, ".state"}, {5'd0, state_out}, {5'd0, st});
    chk({tag, ".input_sel"}, {6'd0, input_sel}, {6'd0, isel});
    chk({tag, ".shift_sel"}, {6'd0, shift_sel}, {6'd0, ssel});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, dn});
    chk({tag, ".clk_ena"}, {7'd0, clk_ena}, {7'd0, ena});
    chk({tag, ".sclr_n"}, {7'd0, sclr_n}, {7'd0, clr_n});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_a  = 1'b1;
    start    = 1'b0;
    count    = 2'b00;

    // 1. Reset
    tick();
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    chk_all("reset", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // 2. Nominal run
    apply(1'b1, 2'b00); chk_all("nom.idle_start", 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    apply(1'b0, 2'b00); chk_all("nom.lsb",        3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 2'b01); chk_all("nom.mid1",       3'b010, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 2'b10); chk_all("nom.mid2",       3'b010, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 2'b11); chk_all("nom.msb",        3'b011, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1); tick();
    apply(1'b0, 2'b00); chk_all("nom.done",       3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1); tick();
    apply(1'b0, 2'b00); chk_all("nom.idle_after", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // 3. Skipped count in MID
    apply(1'b1, 2'b00); tick();
    apply(1'b0, 2'b00); tick();
    apply(1'b0, 2'b11); chk_all("skip.mid_bad",   3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b0, 2'b00); chk_all("skip.err_hold",  3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b1, 2'b00); chk_all("skip.err_start", 3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); tick();

    // 4. start held high in LSB
    apply(1'b1, 2'b00); chk_all("hold.lsb",       3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b0, 2'b00); chk_all("hold.err",       3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset while in ERR
    reset_a = 1'b1; tick();
    apply(1'b0, 2'b00); reset_a = 1'b0; #1;
    chk_all("err_reset", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // 5. Reset mid-operation in MSB
    apply(1'b1, 2'b00); tick();
    apply(1'b0, 2'b00); tick();
    apply(1'b0, 2'b01); tick();
    apply(1'b0, 2'b10); tick();
    apply(1'b0, 2'b11); chk_all("rst.msb", 3'b011, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1);
    reset_a = 1'b1; tick();
    apply(1'b0, 2'b00); chk_all("rst.idle", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    reset_a = 1'b0; tick();
    apply(1'b0, 2'b00); chk_all("rst.idle2", 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // 6. Back-to-back start during CALC_DONE
    apply(1'b1, 2'b00); tick();
    apply(1'b0, 2'b00); tick();
    apply(1'b0, 2'b01); tick();
    apply(1'b0, 2'b10); tick();
    apply(1'b0, 2'b11); tick();
    apply(1'b1, 2'b00); chk_all("b2b.calc_start", 3'b100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1); tick();
    apply(1'b1, 2'b00); chk_all("b2b.err_start",  3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    apply(1'b0, 2'b00); chk_all("b2b.lsb",        3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
